// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;

    localparam int unsigned WORD_W = 9;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/prog_sequencer.sv
// Instruction feeder for the 9-bit processor: walks a program in a 1-cycle
// synchronous ROM, issues each word with a run pulse, supplies the mvi
// immediate, waits for done, and halts at the end of the program.
// Optional build macro PROG_SEQUENCER_DONE_TIMEOUT_EN adds an EXEC watchdog
// that halts with err=1 when done is missing for 7 EXEC cycles.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned PROG_LEN   = 32,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] DIN,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        instr_count,
    output logic              err
);

    localparam int unsigned PC_W = ADDR_W + 1;
    localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] PC_END   = PC_W'(PROG_LEN);

    state_t            state;
    state_t            state_nx;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_adv;
    logic [ADDR_W-1:0] pc_inc_addr;
    logic              is_mvi;
    logic              launch_c;
    logic              retire_c;
    logic              timeout_c;

    // start is only honoured while idle or halted; done only in EXEC
    assign launch_c    = start && ((state == IDLE) || (state == HALT));
    assign retire_c    = done && (state == EXEC);
    assign pc_adv      = pc + (is_mvi ? PC_W'(2) : PC_W'(1));
    assign pc_inc_addr = pc[ADDR_W-1:0] + ADDR_W'(1);

`ifdef PROG_SEQUENCER_DONE_TIMEOUT_EN
    logic [2:0] wd_cnt;

    assign timeout_c = (state == EXEC) && !done && (wd_cnt == 3'd6);

    // Watchdog: cleared on entry to EXEC, counts EXEC cycles without done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= 3'd0;
        end else if (state == ISSUE) begin
            wd_cnt <= 3'd0;
        end else if ((state == EXEC) && !done) begin
            wd_cnt <= wd_cnt + 3'd1;
        end
    end

    // Sticky error flag, cleared by an accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (launch_c) begin
            err <= 1'b0;
        end else if (timeout_c) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HALT: if (start) state_nx = FETCH;
            FETCH:      state_nx = ISSUE;
            ISSUE:      state_nx = EXEC;
            EXEC: begin
                if (done) begin
                    state_nx = (pc_adv >= PC_END) ? HALT : FETCH;
                end else if (timeout_c) begin
                    state_nx = HALT;
                end
            end
            default:    state_nx = IDLE;
        endcase
    end

    // Program counter, retired-instruction counter and mvi flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= PC_START;
            instr_count <= 8'd0;
            is_mvi      <= 1'b0;
        end else begin
            if (launch_c) begin
                pc          <= PC_START;
                instr_count <= 8'd0;
            end else if (retire_c) begin
                pc <= pc_adv;
                if (instr_count != 8'hFF) begin
                    instr_count <= instr_count + 8'd1;
                end
            end
            if (state == ISSUE) begin
                is_mvi <= (mem_rdata[8:6] == OP_MVI);
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        mem_addr = pc[ADDR_W-1:0];
        DIN      = '0;
        run      = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: busy = 1'b1;
            ISSUE: begin
                busy     = 1'b1;
                run      = 1'b1;
                DIN      = mem_rdata;
                mem_addr = pc_inc_addr;
            end
            EXEC: begin
                busy     = 1'b1;
                DIN      = mem_rdata;
                mem_addr = pc_inc_addr;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: three instances (4-word program,
// 1-word program, 1-bit address wrap) each fed by a synchronous ROM model,
// with the bench acting as the processor and a program-level reference model.
module tb_prog_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   regs[8];

    // Instance A: PROG_LEN=4
    logic       start_a, done_a, run_a, busy_a, halted_a, err_a;
    logic [4:0] addr_a;
    logic [8:0] rdata_a, din_a;
    logic [7:0] cnt_a;
    logic [8:0] rom_a[32];

    // Instance B: PROG_LEN=1
    logic       start_b, done_b, run_b, busy_b, halted_b, err_b;
    logic [4:0] addr_b;
    logic [8:0] rdata_b, din_b;
    logic [7:0] cnt_b;
    logic [8:0] rom_b[32];

    // Instance C: ADDR_W=1, PROG_LEN=2 (mvi immediate address wraps)
    logic       start_c, done_c, run_c, busy_c, halted_c, err_c;
    logic [0:0] addr_c;
    logic [8:0] rdata_c, din_c;
    logic [7:0] cnt_c;
    logic [8:0] rom_c[2];

    // sim_sync_rom models: data is the word addressed in the previous cycle
    always_ff @(posedge clock) rdata_a <= rom_a[addr_a];
    always_ff @(posedge clock) rdata_b <= rom_b[addr_b];
    always_ff @(posedge clock) rdata_c <= rom_c[addr_c];

    prog_sequencer #(.ADDR_W(5), .PROG_LEN(4), .START_ADDR(0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .DIN(din_a), .run(run_a), .done(done_a),
        .busy(busy_a), .halted(halted_a), .instr_count(cnt_a), .err(err_a));

    prog_sequencer #(.ADDR_W(5), .PROG_LEN(1), .START_ADDR(0)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .DIN(din_b), .run(run_b), .done(done_b),
        .busy(busy_b), .halted(halted_b), .instr_count(cnt_b), .err(err_b));

    prog_sequencer #(.ADDR_W(1), .PROG_LEN(2), .START_ADDR(0)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .mem_addr(addr_c),
        .mem_rdata(rdata_c), .DIN(din_c), .run(run_c), .done(done_c),
        .busy(busy_c), .halted(halted_c), .instr_count(cnt_c), .err(err_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Processor behaviour applied to the words actually seen on DIN
    task automatic proc_exec(input logic [8:0] ins, input logic [8:0] imm);
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        op = ins[8:6];
        rx = ins[5:3];
        ry = ins[2:0];
        case (op)
            3'd0:    regs[rx] = regs[ry];
            3'd1:    regs[rx] = int'(imm);
            3'd2:    regs[rx] = (regs[rx] + regs[ry]) & 511;
            3'd3:    regs[rx] = (regs[rx] - regs[ry]) & 511;
            default: ;
        endcase
    endtask

    // Run instance A from a start pulse to HALT. mode 0: processor timing
    // (mv/mvi done in 1st EXEC cycle, add/sub in 3rd); otherwise random delay.
    task automatic walk_a(input int mode);
        int         pc_m = 0;
        int         cnt_m = 0;
        int         dly;
        logic [2:0] op;
        logic [8:0] ins_obs;
        logic [8:0] imm_obs;
        imm_obs = '0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        while (pc_m < 4) begin
            check("fetch_busy", 32'(busy_a), 1);
            check("fetch_addr", 32'(addr_a), pc_m % 32);
            @(negedge clock);
            check("issue_run", 32'(run_a), 1);
            check("issue_din", 32'(din_a), 32'(rom_a[pc_m]));
            check("issue_addr", 32'(addr_a), (pc_m + 1) % 32);
            ins_obs = din_a;
            op = rom_a[pc_m][8:6];
            if (mode == 0) dly = (op >= 3'd2) ? 2 : 0;
            else           dly = int'($urandom_range(3, 0));
            @(negedge clock);
            for (int k = 0; k <= dly; k++) begin
                check("exec_run", 32'(run_a), 0);
                check("exec_din", 32'(din_a), 32'(rom_a[(pc_m + 1) % 32]));
                if (k == 0) imm_obs = din_a;
                if (k == dly) done_a = 1'b1;
                @(negedge clock);
                done_a = 1'b0;
            end
            proc_exec(ins_obs, imm_obs);
            pc_m += (op == 3'd1) ? 2 : 1;
            cnt_m++;
        end
        check("halt_flag", 32'(halted_a), 1);
        check("halt_busy", 32'(busy_a), 0);
        check("halt_din", 32'(din_a), 0);
        check("halt_count", 32'(cnt_a), cnt_m);
        check("halt_err", 32'(err_a), 0);
    endtask

    // Absolute safety net
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int q_cyc[$];
        int q_addr[$];
        int q_din[$];
        int exp_cyc[3]  = '{2, 5, 8};
        int exp_addr[3] = '{1, 3, 4};
        int exp_din[3]  = '{'h040, 'h008, 'h081};

        reset = 1'b1;
        start_a = 1'b0; done_a = 1'b0;
        start_b = 1'b0; done_b = 1'b0;
        start_c = 1'b0; done_c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = 9'h000;
            rom_b[i] = 9'h000;
        end
        rom_a[0] = 9'h040; rom_a[1] = 9'h005; rom_a[2] = 9'h008; rom_a[3] = 9'h081;
        rom_b[0] = 9'h040; rom_b[1] = 9'h1A5;
        rom_c[0] = 9'h008; rom_c[1] = 9'h040;
        for (int i = 0; i < 8; i++) regs[i] = 0;

        // Reset values
        #12;
        check("rst_run", 32'(run_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_halted", 32'(halted_a), 0);
        check("rst_din", 32'(din_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_addr", 32'(addr_a), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", 32'(busy_a), 0);

        // Directed program with processor timing
        walk_a(0);
        check("proc_r0", regs[0], 10);
        check("proc_r1", regs[1], 5);

        // done held high: run pulses every 3 cycles, pc 0->2->3->4
        done_a = 1'b1;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (run_a) begin
                q_cyc.push_back(c);
                q_addr.push_back(int'(addr_a));
                q_din.push_back(int'(din_a));
            end
            if (c == 10) check("fast_halt", 32'(halted_a), 1);
            @(negedge clock);
        end
        done_a = 1'b0;
        check("fast_nrun", q_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("fast_cycle", (i < q_cyc.size()) ? q_cyc[i] : -1, exp_cyc[i]);
            check("fast_addr", (i < q_addr.size()) ? q_addr[i] : -1, exp_addr[i]);
            check("fast_din", (i < q_din.size()) ? q_din[i] : -1, exp_din[i]);
        end
        check("fast_count", 32'(cnt_a), 3);

        // Asynchronous reset during EXEC of the add
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            done_a = (c == 3 || c == 6);
            @(negedge clock);
        end
        done_a = 1'b0;
        check("pre_rst_busy", 32'(busy_a), 1);
        check("pre_rst_din", 32'(din_a), 'h081 & 0 | 32'(rom_a[4]));
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_a), 0);
        check("async_rst_run", 32'(run_a), 0);
        check("async_rst_count", 32'(cnt_a), 0);
        check("async_rst_addr", 32'(addr_a), 0);
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous reset during ISSUE drops run at once
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        check("issue_pre_rst_run", 32'(run_a), 1);
        #2 reset = 1'b1;
        #1;
        check("issue_rst_run", 32'(run_a), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Resume from address 0 after reset
        walk_a(0);

        // start during EXEC is ignored; start in HALT restarts
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            done_a = (c == 3 || c == 6);
            @(negedge clock);
        end
        done_a = 1'b0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        check("exec_start_addr", 32'(addr_a), 4);
        check("exec_start_busy", 32'(busy_a), 1);
        check("exec_start_count", 32'(cnt_a), 2);
        done_a = 1'b1;
        @(negedge clock);
        done_a = 1'b0;
        check("exec_start_halt", 32'(halted_a), 1);
        check("exec_start_final", 32'(cnt_a), 3);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        check("restart_busy", 32'(busy_a), 1);
        check("restart_addr", 32'(addr_a), 0);
        check("restart_count", 32'(cnt_a), 0);
        done_a = 1'b1;
        repeat (12) @(negedge clock);
        done_a = 1'b0;
        check("restart_halt", 32'(halted_a), 1);

        // Random programs and random done latency
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < 32; i++) begin
                rom_a[i] = {3'($urandom_range(3, 0)), 6'($urandom)};
            end
            walk_a(1);
        end

        // One-word program: immediate from address 1, then HALT
        check("b_idle", 32'(halted_b), 0);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        check("b_fetch_addr", 32'(addr_b), 0);
        @(negedge clock);
        check("b_issue_din", 32'(din_b), 'h040);
        check("b_issue_addr", 32'(addr_b), 1);
        @(negedge clock);
        check("b_exec_din", 32'(din_b), 'h1A5);
        done_b = 1'b1;
        @(negedge clock);
        done_b = 1'b0;
        check("b_halt", 32'(halted_b), 1);
        check("b_count", 32'(cnt_b), 1);

        // mvi as last word with a 1-bit ROM address: immediate wraps to 0
        start_c = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        @(negedge clock);
        check("c_issue0_din", 32'(din_c), 'h008);
        @(negedge clock);
        done_c = 1'b1;
        @(negedge clock);
        done_c = 1'b0;
        check("c_fetch1_addr", 32'(addr_c), 1);
        @(negedge clock);
        check("c_issue1_din", 32'(din_c), 'h040);
        check("c_issue1_addr", 32'(addr_c), 0);
        @(negedge clock);
        check("c_exec1_din", 32'(din_c), 'h008);
        done_c = 1'b1;
        @(negedge clock);
        done_c = 1'b0;
        check("c_halt", 32'(halted_c), 1);
        check("c_count", 32'(cnt_c), 2);
        check("c_halt_addr", 32'(addr_c), 1);

`ifdef PROG_SEQUENCER_DONE_TIMEOUT_EN
        // done never arrives: 7 EXEC cycles then HALT with err
        done_a = 1'b0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        for (int c = 0; c < 7; c++) begin
            check("wd_exec_busy", 32'(busy_a), 1);
            @(negedge clock);
        end
        check("wd_halt", 32'(halted_a), 1);
        check("wd_err", 32'(err_a), 1);
        check("wd_count", 32'(cnt_a), 0);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        check("wd_err_clear", 32'(err_a), 0);
        check("wd_restart_addr", 32'(addr_a), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
